// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streamed program loader: writes N words at base B into imem, then releases CPU reset (optional checksum: PROG_LOADER_CHECKSUM_EN)
module prog_loader #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_BASE    = 3'd2,
    S_DATA    = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CKSUM   = 3'd4,
`endif
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // Wide enough to hold base + length of any incoming word without wrapping.
  localparam int SW = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 2;
  localparam logic [SW-1:0] LIMIT = SW'(1) << ADDR_W;
  localparam logic [31:0] REL_LAST = (RELEASE_CYCLES > 0) ? 32'(RELEASE_CYCLES - 1) : 32'd0;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   addr_q;
  logic [31:0]       rel_cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
`endif

  logic [SW-1:0] end_excl;
  logic          len_too_big;
  logic          last_word;

  // One past the last address that the session would write (base word is on in_data).
  assign end_excl    = SW'(in_data) + SW'(len_q);
  assign len_too_big = SW'(in_data) > LIMIT;
  assign last_word   = (idx_q == (len_q - (ADDR_W+1)'(1)));

  // Accept words only in the header/payload states; reset blocks acceptance at once.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN, S_BASE, S_DATA: in_ready = reset;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CKSUM:               in_ready = reset;
`endif
      default:               in_ready = 1'b0;
    endcase
  end

  assign imem_we    = reset && (state == S_DATA) && in_valid;
  assign imem_addr  = imem_we ? addr_q[ADDR_W-1:0] : '0;
  assign imem_wdata = imem_we ? in_data : '0;

  assign cpu_reset  = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

  // Session FSM with length/base checks, address walk and release timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rel_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state   <= S_LEN;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            rel_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        S_LEN: begin
          if (in_valid) begin
            len_q <= (ADDR_W+1)'(in_data);
            state <= ((in_data == '0) || len_too_big) ? S_ERR : S_BASE;
          end
        end
        S_BASE: begin
          if (in_valid) begin
            addr_q <= (ADDR_W+1)'(in_data);
            idx_q  <= '0;
            state  <= (end_excl > LIMIT) ? S_ERR : S_DATA;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            addr_q  <= addr_q + (ADDR_W+1)'(1);
            idx_q   <= idx_q + (ADDR_W+1)'(1);
            rel_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_q + in_data;
            if (last_word) state <= S_CKSUM;
`else
            if (last_word) state <= S_RELEASE;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CKSUM: begin
          if (in_valid) state <= (in_data == sum_q) ? S_RELEASE : S_ERR;
        end
`endif
        S_RELEASE: begin
          if (rel_cnt == REL_LAST) state <= S_DONE;
          else rel_cnt <= rel_cnt + 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader (vector table, reset sequence, randomized sessions)
module tb_prog_loader;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RC = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  prog_loader #(.DATA_W(DW), .ADDR_W(AW), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  typedef struct {
    string           name;
    int              n;
    logic [15:0]     b;
    logic [3:0][15:0] d;
    logic [15:0]     cks;
    int              gap_after;
    bit              exp_done;
    int              exp_nwr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] stream_q[$];
  logic [15:0] data_q[$];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  bit          accepted;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at negedge, sample 1 time unit later, log any imem write.
  task automatic tick(input logic v, input logic [15:0] d, input logic s);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    start    = s;
    #1;
    accepted = in_valid && in_ready;
    if (imem_we) begin
      chk("we_needs_transfer", {31'b0, accepted}, 32'd1);
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  endtask

  task automatic run_session(input int gap_after, input bit stalls, output int rel_cnt);
    int budget;
    bit abort;
    abort   = 1'b0;
    rel_cnt = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b0);
    chk("start_done_low", {31'b0, done}, 32'd0);
    chk("start_error_low", {31'b0, error}, 32'd0);
    chk("start_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    for (int i = 0; i < stream_q.size() && !abort; i++) begin
      if (gap_after >= 0 && i == gap_after + 2) repeat (5) tick(1'b0, 16'h0, 1'b0);
      budget = 0;
      do begin
        if (stalls && $urandom_range(0, 3) == 0) tick(1'b0, 16'($urandom), 1'b0);
        tick(1'b1, stream_q[i], 1'b0);
        budget++;
        if (!accepted && (error || budget > 40)) abort = 1'b1;
      end while (!accepted && !abort);
    end
    for (int c = 0; c < 30 && !done && !error; c++) begin
      tick(1'b0, 16'h0, 1'b0);
      if (cpu_reset && !error) rel_cnt++;
    end
  endtask

  task automatic check_result(input string name, input bit exp_done, input int exp_nwr,
                              input logic [15:0] b, input int rel_cnt);
    chk({name, "_nwr"}, wr_addr_q.size(), exp_nwr);
    for (int k = 0; k < wr_addr_q.size() && k < exp_nwr; k++) begin
      chk({name, "_addr"}, {16'b0, wr_addr_q[k]}, {16'b0, 16'(b + 16'(k))});
      chk({name, "_data"}, {16'b0, wr_data_q[k]}, {16'b0, data_q[k]});
    end
    chk({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
    chk({name, "_error"}, {31'b0, error}, {31'b0, !exp_done});
    chk({name, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, !exp_done});
    if (exp_done) chk({name, "_release_cycles"}, rel_cnt, RC);
  endtask

  task automatic run_vec(input vec_t v);
    int rel;
    stream_q = {16'(v.n), v.b};
    data_q.delete();
    for (int k = 0; k < v.n && k < 4; k++) begin
      data_q.push_back(v.d[k]);
      stream_q.push_back(v.d[k]);
    end
    if (CK) stream_q.push_back(v.cks);
    run_session(v.gap_after, 1'b0, rel);
    check_result(v.name, v.exp_done, v.exp_nwr, v.b, rel);
  endtask

  initial begin
    int          rel;
    int          n;
    logic [15:0] b;
    logic [15:0] sum;
    logic [15:0] cks;
    bit          fits;
    bit          exp_done;

    vecs[0] = '{"cks_ok",    3, 16'h0010, {16'h0000, 16'hE000, 16'h2222, 16'h1111}, 16'h1333, -1, 1'b1, 3};
    vecs[1] = '{"cks_bad",   3, 16'h0010, {16'h0000, 16'hE000, 16'h2222, 16'h1111}, 16'h1334, -1, !CK,  3};
    vecs[2] = '{"len_zero",  0, 16'h0000, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, -1, 1'b0, 0};
    vecs[3] = '{"base_ovf",  2, 16'hFFFF, {16'h0000, 16'h0000, 16'h0006, 16'h0005}, 16'h000B, -1, 1'b0, 0};
    vecs[4] = '{"gap",       4, 16'h0100, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h000A,  2, 1'b1, 4};
    vecs[5] = '{"top_one",   1, 16'hFFFF, {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 16'hBEEF, -1, 1'b1, 1};
    vecs[6] = '{"top_two",   2, 16'hFFFE, {16'h0000, 16'h0000, 16'h8001, 16'h8000}, 16'h0001, -1, 1'b1, 2};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick(1'b0, 16'h0, 1'b0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_imem_addr", {16'b0, imem_addr}, 32'd0);
    chk("rst_imem_wdata", {16'b0, imem_wdata}, 32'd0);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    reset = 1'b1;
    tick(1'b0, 16'h0, 1'b0);
    chk("idle_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset after the second of four payload words.
    wr_addr_q.delete();
    wr_data_q.delete();
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b1, 16'd4, 1'b0);
    tick(1'b1, 16'h0200, 1'b0);
    tick(1'b1, 16'hA001, 1'b0);
    tick(1'b1, 16'hA002, 1'b0);
    reset = 1'b0;
    tick(1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 16'h0, 1'b0);
    chk("midrst_nwr", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("midrst_addr1", {16'b0, wr_addr_q[1]}, 32'h0201);
      chk("midrst_data1", {16'b0, wr_data_q[1]}, 32'hA002);
    end
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("midrst_imem_addr", {16'b0, imem_addr}, 32'd0);
    chk("midrst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_error", {31'b0, error}, 32'd0);
    run_vec(vecs[4]);

    // Randomized sessions against a whole-session reference model.
    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      b = ($urandom_range(0, 1) == 1) ? 16'hFFFF - 16'($urandom_range(0, 9)) : 16'($urandom);
      data_q.delete();
      sum = 16'h0;
      for (int k = 0; k < n; k++) begin
        data_q.push_back(16'($urandom));
        sum = sum + data_q[k];
      end
      cks = sum + ((CK && $urandom_range(0, 2) == 0) ? 16'd1 : 16'd0);
      fits = (n != 0) && (int'(b) + n <= 65536);
      exp_done = fits && (!CK || cks == sum);
      stream_q = {16'(n), b};
      for (int k = 0; k < n; k++) stream_q.push_back(data_q[k]);
      if (CK) stream_q.push_back(cks);
      run_session(-1, 1'b1, rel);
      check_result("rand", exp_done, fits ? n : 0, b, rel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 16, the instruction memory address width.
REQ-003 SHALL have parameter RELEASE_CYCLES, default 4, the number of cycles the CPU reset is held after the last write, for pipeline flush.
REQ-004 SHALL have the ports below, clock and reset first:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  stream word valid.
- in_data  input  DATA_W  stream word.
- in_ready  output  1  loader accepts in_data this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- cpu_reset  output  1  active-high reset driven to the CPU.
- done  output  1  load complete and CPU released (sticky).
- error  output  1  load aborted (sticky).

Function
REQ-005 SHALL implement states IDLE, LEN, BASE, DATA, CKSUM, RELEASE, DONE, ERR.
REQ-006 A word transfers only on a cycle where in_valid and in_ready are both 1; in_ready is 1 only in LEN, BASE, DATA and CKSUM.
REQ-007 IDLE: cpu_reset=1; start moves to LEN next cycle; start is ignored in every other state except DONE and ERR.
REQ-008 LEN: the accepted word is the count N; N=0 goes to ERR, otherwise go to BASE.
REQ-009 BASE: the accepted word is the base address B; if B+N-1 exceeds 2^ADDR_W-1, go to ERR (no wrap-around permitted), otherwise go to DATA.
REQ-010 DATA: each accepted word k (0..N-1) drives imem_we=1, imem_addr=B+k, imem_wdata=word in the same cycle (combinational, zero latency); the last word goes to CKSUM if the checksum feature is enabled, else to RELEASE.
REQ-011 imem_we SHALL be 0 in every cycle without a DATA-state transfer; in_valid=0 stalls with no write.
REQ-012 RELEASE: cpu_reset stays 1 for exactly RELEASE_CYCLES cycles, then the block enters DONE.
REQ-013 DONE: cpu_reset=0 and done=1; start returns to LEN with done cleared and cpu_reset reasserted next cycle.
REQ-014 ERR: cpu_reset=1 and error=1; start returns to LEN with error cleared.
REQ-015 cpu_reset SHALL be 1 in every state except DONE.
REQ-016 Word and address counters SHALL be ADDR_W+1 bits so that N=2^ADDR_W-1 with B=0 completes without overflow.

Reset
REQ-017 reset=0 at a clk edge SHALL force IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, and all counters and checksum cleared.
REQ-018 Reset mid-session SHALL abandon the load immediately with no further writes; words already written are not undone.

Configuration
REQ-019 Macro PROG_LOADER_CHECKSUM_EN defined: after the last DATA word, CKSUM accepts one word that is compared with the mod-2^DATA_W sum of all N data words; a match goes to RELEASE, a mismatch goes to ERR.
REQ-020 Macro not defined: the CKSUM state and the adder are absent, and the last DATA word goes directly to RELEASE.

Verification
REQ-021 Stream N=3, B=0x0010, data 0x1111/0x2222/0xE000, with the checksum feature enabled and checksum 0x1333 -> writes at addresses 0x10, 0x11, 0x12; cpu_reset falls 4 cycles after the last write; done=1.
REQ-022 Same stream with checksum 0x1334 -> error=1, cpu_reset stays 1, done=0.
REQ-023 Stream N=0 -> ERR after the LEN word, with no imem_we pulse.
REQ-024 Stream N=2, B=0xFFFF -> ERR after the BASE word, with no write.
REQ-025 Deassert in_valid for 5 cycles midway through DATA -> no writes during the gap, addresses contiguous, final state DONE.
REQ-026 Assert reset=0 after the 2nd of 4 DATA words -> exactly 2 writes; next cycle shows IDLE with all outputs at reset values; start after reset completes a fresh load.
